sweep_driver: RTL and testbench

Upstream stage of the peak-search path. Steps a 16-bit key across a programmed range and holds each key for a fixed dwell. Quantizes the raw sample stream into 2-bit levels and emits the key, data and enable triple consumed by the downstream peak-tracking stage. Also pulses that stage's clear line at sweep start and raises `done` when the last key's measurement window closes.

---
 rtl/sweep_driver_pkg.sv | 17 +
 rtl/sweep_driver_level_quantizer.sv | 37 +++
 rtl/sweep_driver.sv | 119 +++++++++++
 tb/tb_sweep_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_driver_pkg.sv
// Shared types for the sweep driver slice: FSM states, dwell counter and level.
package sweep_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_DONE
  } state_t;

  // Dwell counter width; SETTLE+MEASURE-1 must fit.
  localparam int unsigned DWELL_W = 16;
  typedef logic [DWELL_W-1:0] dwell_t;

  // Quantized sample level.
  typedef logic [1:0] level_t;

endpackage

// File: rtl/sweep_driver_level_quantizer.sv
// Registered 3-threshold quantizer: maps a raw sample onto a 2-bit level.
module level_quantizer
  import sweep_driver_pkg::*;
#(
  parameter int unsigned N_SAMPLE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SAMPLE-1:0] sample,
  input  logic [N_SAMPLE-1:0] thr_lo,
  input  logic [N_SAMPLE-1:0] thr_mid,
  input  logic [N_SAMPLE-1:0] thr_hi,
  output level_t              data
);

  level_t level_d;

  // Priority compare against live thresholds; lowest threshold wins first.
  always_comb begin
    level_d = 2'd3;
    if (sample < thr_lo)
      level_d = 2'd0;
    else if (sample < thr_mid)
      level_d = 2'd1;
    else if (sample < thr_hi)
      level_d = 2'd2;
  end

  // Register the level, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset)
      data <= '0;
    else
      data <= level_d;
  end

endmodule

// File: rtl/sweep_driver.sv
// Sweep driver: steps a key across a programmed range, dwelling SETTLE cycles
// with enable low then MEASURE cycles with enable high on each key.
module sweep_driver
  import sweep_driver_pkg::*;
#(
  parameter int unsigned N_KEY    = 16,
  parameter int unsigned N_SAMPLE = 8,
  parameter int unsigned SETTLE   = 10,
  parameter int unsigned MEASURE  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_KEY-1:0]    key_first,
  input  logic [N_KEY-1:0]    key_last,
  input  logic [N_KEY-1:0]    key_step,
  input  logic [N_SAMPLE-1:0] sample,
  input  logic [N_SAMPLE-1:0] thr_lo,
  input  logic [N_SAMPLE-1:0] thr_mid,
  input  logic [N_SAMPLE-1:0] thr_hi,
  output logic [N_KEY-1:0]    key,
  output logic [1:0]          data,
  output logic                enable,
  output logic                clear_max,
  output logic                busy,
  output logic                done
);

  localparam dwell_t SETTLE_CNT = dwell_t'(SETTLE);
  localparam dwell_t LAST_CNT   = dwell_t'(SETTLE + MEASURE - 1);

  state_t           state_q, state_n;
  logic [N_KEY-1:0] key_q, key_n;
  logic [N_KEY-1:0] last_q, last_n;
  logic [N_KEY-1:0] step_q, step_n;
  dwell_t           cnt_q, cnt_n;
  logic             first_q, first_n;
  logic [N_KEY:0]   nxt;

  level_quantizer #(
    .N_SAMPLE(N_SAMPLE)
  ) u_quant (
    .clk    (clk),
    .reset  (reset),
    .sample (sample),
    .thr_lo (thr_lo),
    .thr_mid(thr_mid),
    .thr_hi (thr_hi),
    .data   (data)
  );

  // Extra carry bit so a step past the top of the key range ends the sweep
  // instead of wrapping to a small key.
  assign nxt = {1'b0, key_q} + {1'b0, step_q};

  // State, key, counter and latched configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      last_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      last_q  <= last_n;
      step_q  <= step_n;
      cnt_q   <= cnt_n;
      first_q <= first_n;
    end
  end

  // Next-state logic: accept start, count the dwell, step or finish.
  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    last_n  = last_q;
    step_n  = step_q;
    cnt_n   = cnt_q;
    first_n = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_DWELL;
          key_n   = key_first;
          last_n  = key_last;
          step_n  = (key_step == '0) ? N_KEY'(1) : key_step;
          cnt_n   = '0;
          first_n = 1'b1;
        end
      end
      ST_DWELL: begin
        if (cnt_q == LAST_CNT) begin
          first_n = 1'b0;
          if (nxt[N_KEY] || (nxt[N_KEY-1:0] > last_q)) begin
            state_n = ST_DONE;
            cnt_n   = '0;
          end else begin
            key_n = nxt[N_KEY-1:0];
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt_q + dwell_t'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign key       = key_q;
  assign enable    = (state_q == ST_DWELL) && (cnt_q >= SETTLE_CNT);
  assign clear_max = (state_q == ST_DWELL) && (cnt_q == '0) && first_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sweep_driver.sv
// Directed self-checking bench for sweep_driver with default parameters.
module tb_sweep_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] key_first, key_last, key_step;
  logic [7:0]  sample, thr_lo, thr_mid, thr_hi;
  logic [15:0] key;
  logic [1:0]  data;
  logic        enable, clear_max, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  sweep_driver #(
    .N_KEY   (16),
    .N_SAMPLE(8),
    .SETTLE  (10),
    .MEASURE (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_first(key_first),
    .key_last (key_last),
    .key_step (key_step),
    .sample   (sample),
    .thr_lo   (thr_lo),
    .thr_mid  (thr_mid),
    .thr_hi   (thr_hi),
    .key      (key),
    .data     (data),
    .enable   (enable),
    .clear_max(clear_max),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a config with start for one edge; returns in cycle 1 of the sweep.
  task automatic do_start(input logic [15:0] f, input logic [15:0] l, input logic [15:0] s);
    key_first = f;
    key_last  = l;
    key_step  = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in cycle 1; checks every cycle through the first IDLE cycle after DONE.
  // 14 cycles per key: phases 0..9 settle, 10..13 measure.
  task automatic check_sweep(input string name, input logic [15:0] k0,
                             input logic [15:0] kstep, input int nkeys);
    int d;
    logic [15:0] ek;
    logic een, ecl, ebs, edn;
    d = nkeys * 14;
    for (int c = 1; c <= d + 2; c++) begin
      if (c <= d) begin
        ek  = k0 + 16'((c - 1) / 14) * kstep;
        een = ((c - 1) % 14) >= 10;
        ecl = (c == 1);
        ebs = 1'b1;
        edn = 1'b0;
      end else begin
        ek  = k0 + 16'(nkeys - 1) * kstep;
        een = 1'b0;
        ecl = 1'b0;
        ebs = (c == d + 1);
        edn = (c == d + 1);
      end
      n_checks++;
      if (key !== ek) begin
        n_fail++;
        $display("FAIL %s key cycle %0d: got %h expected %h", name, c, key, ek);
      end
      n_checks++;
      if (enable !== een) begin
        n_fail++;
        $display("FAIL %s enable cycle %0d: got %b expected %b", name, c, enable, een);
      end
      n_checks++;
      if (clear_max !== ecl) begin
        n_fail++;
        $display("FAIL %s clear_max cycle %0d: got %b expected %b", name, c, clear_max, ecl);
      end
      n_checks++;
      if (busy !== ebs) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, ebs);
      end
      n_checks++;
      if (done !== edn) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, edn);
      end
      if (c < d + 2) tick();
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_checks++;
    if ({key, data, enable, clear_max, busy, done} !== 22'd0) begin
      n_fail++;
      $display("FAIL %s outputs: got key=%h data=%0d en=%b clr=%b busy=%b done=%b expected all 0",
               name, key, data, enable, clear_max, busy, done);
    end
  endtask

  task automatic test_reset();
    check_idle_zero("reset_state");
    reset = 1'b1;
    start = 1'b1;
    key_first = 16'd9;
    tick();
    check_idle_zero("reset_beats_start");
    start = 1'b0;
    reset = 1'b0;
    tick();
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_quantizer();
    logic [7:0] smp [8] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    logic [1:0] exp [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      sample = smp[i];
      tick();
      n_checks++;
      if (data !== exp[i]) begin
        n_fail++;
        $display("FAIL quant sample=%0d: got %0d expected %0d", smp[i], data, exp[i]);
      end
    end
    sample = 8'd0;
    tick();
  endtask

  task automatic test_basic();
    do_start(16'd100, 16'd103, 16'd1);
    check_sweep("basic", 16'd100, 16'd1, 4);
  endtask

  task automatic test_overflow();
    do_start(16'hFFF0, 16'hFFFF, 16'd8);
    check_sweep("overflow", 16'hFFF0, 16'd8, 2);
    tick();
    do_start(16'd50, 16'd20, 16'd1);
    check_sweep("reversed", 16'd50, 16'd1, 1);
    tick();
  endtask

  task automatic test_zero_step();
    do_start(16'd5, 16'd7, 16'd0);
    check_sweep("zero_step", 16'd5, 16'd1, 3);
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(16'd100, 16'd103, 16'd1);
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid enable before reset: got %b expected 1", enable);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("reset_mid");
    tick();
    check_idle_zero("reset_mid_idle");
    do_start(16'd100, 16'd103, 16'd1);
    check_sweep("after_reset", 16'd100, 16'd1, 4);
    tick();
  endtask

  task automatic test_start_held();
    key_first = 16'd100;
    key_last  = 16'd103;
    key_step  = 16'd1;
    start     = 1'b1;
    tick();
    check_sweep("start_held", 16'd100, 16'd1, 4);
    tick();
    n_checks++;
    if ({clear_max, busy, enable, done, key} !== {4'b1100, 16'd100}) begin
      n_fail++;
      $display("FAIL restart: got clr=%b busy=%b en=%b done=%b key=%h expected clr=1 busy=1 en=0 done=0 key=0064",
               clear_max, busy, enable, done, key);
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (clear_max !== 1'b0) begin
      n_fail++;
      $display("FAIL restart clear_max second cycle: got %b expected 0", clear_max);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    key_first = '0;
    key_last  = '0;
    key_step  = '0;
    sample    = 8'd0;
    thr_lo    = 8'd64;
    thr_mid   = 8'd128;
    thr_hi    = 8'd192;
    repeat (3) tick();
    test_reset();
    test_quantizer();
    test_basic();
    tick();
    test_overflow();
    test_zero_step();
    test_reset_mid();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
